pht_upd_sched: RTL

Controller for the branch predictor's pattern history table (PHT) of saturating-counter entries. It holds the table and queues resolved-branch updates. It arbitrates the table's single read port between prediction lookups and update read-modify-writes. Each update is sequenced through the external `fin_sta_mac` counter FSM datapath, and the result is written back.

---
 rtl/pht_upd_sched.sv | 172 +++++++++++++++++
 1 files changed

// File: rtl/pht_upd_sched.sv
// PHT controller: saturating-counter table with a queued update path that shares
// the single read port with prediction lookups and writes back via fin_sta_mac.
module pht_upd_sched #(
  parameter int IDX_W      = 4,
  parameter int CTR_W      = 2,
  parameter int QDEPTH     = 4,
  parameter int STARVE_MAX = 3
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             lk_valid,
  input  logic [IDX_W-1:0] lk_idx,
  output logic             lk_ready,
  output logic             lk_resp_valid,
  output logic             lk_taken,
  input  logic             up_valid,
  input  logic [IDX_W-1:0] up_idx,
  input  logic             up_torn,
  output logic             up_ready,
  output logic             fsm_torn,
  output logic [CTR_W-1:0] fsm_cur,
  input  logic [CTR_W-1:0] fsm_next,
  output logic             busy
);

  localparam int ENTRIES = 1 << IDX_W;
  localparam int PTR_W   = (QDEPTH > 1) ? $clog2(QDEPTH) : 1;
  localparam int CNT_W   = $clog2(QDEPTH + 1);
  localparam int SC_W    = (STARVE_MAX > 0) ? $clog2(STARVE_MAX + 1) : 1;

  localparam logic [CTR_W-1:0] CTR_INIT   = CTR_W'(1);
  localparam logic [CNT_W-1:0] CNT_FULL   = CNT_W'(QDEPTH);
  localparam logic [SC_W-1:0]  STARVE_LIM = SC_W'(STARVE_MAX);

  typedef enum logic {
    S_IDLE,
    S_WRITE
  } state_t;

  state_t state, state_nxt;

  logic [CTR_W-1:0] pht_q [ENTRIES];

  logic [IDX_W-1:0] q_idx  [QDEPTH];
  logic             q_torn [QDEPTH];
  logic [PTR_W-1:0] rd_ptr, wr_ptr;
  logic [CNT_W-1:0] count;

  logic [SC_W-1:0]  starve_cnt;
  logic [CTR_W-1:0] cur_reg;
  logic             torn_reg;
  logic [IDX_W-1:0] idx_reg;

  logic q_empty, q_full;
  logic push, pop;
  logic lk_fire, upd_read, pht_we;

  assign q_empty  = (count == '0);
  assign q_full   = (count == CNT_FULL);
  assign up_ready = ~q_full;
  assign push     = up_valid & up_ready;

  // Lookups win the read port in IDLE unless starvation has forced an update.
  assign lk_fire  = lk_valid & lk_ready;
  assign upd_read = (state == S_IDLE) & ~q_empty & ~lk_fire;
  assign pop      = upd_read;

  assign busy = ~q_empty | (state == S_WRITE);

  always_ff @(posedge clk) begin
    if (reset) begin
      state <= S_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE:  if (upd_read) state_nxt = S_WRITE;
      S_WRITE: state_nxt = S_IDLE;
      default: state_nxt = S_IDLE;
    endcase
  end

  always_comb begin
    lk_ready = 1'b1;
    fsm_torn = 1'b0;
    fsm_cur  = '0;
    pht_we   = 1'b0;
    case (state)
      S_IDLE: begin
        if (!q_empty && starve_cnt == STARVE_LIM) lk_ready = 1'b0;
      end
      S_WRITE: begin
        fsm_torn = torn_reg;
        fsm_cur  = cur_reg;
        pht_we   = 1'b1;
      end
      default: begin
        lk_ready = 1'b1;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < ENTRIES; i++) pht_q[i] <= CTR_INIT;
    end else if (pht_we) begin
      pht_q[idx_reg] <= fsm_next;
    end
  end

  // Queue payload needs no reset; count and pointers define what is valid.
  always_ff @(posedge clk) begin
    if (push) begin
      q_idx[wr_ptr]  <= up_idx;
      q_torn[wr_ptr] <= up_torn;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      starve_cnt <= '0;
    end else if (upd_read) begin
      starve_cnt <= '0;
    end else if (state == S_IDLE && !q_empty && lk_fire && starve_cnt != STARVE_LIM) begin
      starve_cnt <= starve_cnt + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      cur_reg  <= '0;
      torn_reg <= 1'b0;
      idx_reg  <= '0;
    end else if (upd_read) begin
      cur_reg  <= pht_q[q_idx[rd_ptr]];
      torn_reg <= q_torn[rd_ptr];
      idx_reg  <= q_idx[rd_ptr];
    end
  end

  // A lookup in the WRITE cycle samples the table before the write lands.
  always_ff @(posedge clk) begin
    if (reset) begin
      lk_resp_valid <= 1'b0;
      lk_taken      <= 1'b0;
    end else begin
      lk_resp_valid <= lk_fire;
      if (lk_fire) lk_taken <= pht_q[lk_idx][CTR_W-1];
    end
  end

endmodule
